// File: rtl/piso_pkg.sv
// Shared types for the piso_tx serializer: FSM state enum and counter sizing helper.
// Optional macro PISO_TX_PARITY_EN adds the PARITY state for the even-parity trailer bit.
package piso_pkg;

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } state_t;
`else
    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;
`endif

    function automatic int cntWidth(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Down-counter tracking how many data bits of the current frame remain on the wire.
// Loads WIDTH on capture, steps down once per sent bit and saturates at zero.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = cntWidth(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_isLast
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CW'(WIDTH);
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    // A count of one means the bit currently on so is the last data bit.
    assign o_isLast = (r_count == CW'(1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load handshake and done pulse.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shifted;
    logic             r_so;
    logic             w_soNext;
    logic             w_isLast;
    logic             w_final;
    logic             w_ready;
    logic             w_load;
`ifdef PISO_TX_PARITY_EN
    logic             r_par;
`endif

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_dec    (r_state == SHIFT),
        .o_isLast (w_isLast)
    );

    always_comb begin
        w_next    = r_state;
        w_final   = 1'b0;
        w_soNext  = 1'b0;
        w_shifted = '0;

        if (MSB_FIRST != 0) begin
            w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
        end else begin
            w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
        end

        case (r_state)
            SHIFT: begin
`ifndef PISO_TX_PARITY_EN
                w_final = w_isLast;
`endif
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: w_final = 1'b1;
`endif
            default: w_final = 1'b0;
        endcase

        w_ready = (r_state == IDLE) || w_final;
        w_load  = load_valid && w_ready;

        case (r_state)
            IDLE: begin
                if (w_load) w_next = SHIFT;
            end
            SHIFT: begin
                if (w_isLast) begin
`ifdef PISO_TX_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = w_load ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: w_next = w_load ? SHIFT : IDLE;
`endif
            default: w_next = IDLE;
        endcase

        // The bit for the next cycle is chosen here so that so itself stays a flop.
        if (w_load) begin
            w_soNext = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
        end else if ((r_state == SHIFT) && !w_isLast) begin
            w_soNext = (MSB_FIRST != 0) ? w_shifted[WIDTH-1] : w_shifted[0];
`ifdef PISO_TX_PARITY_EN
        end else if ((r_state == SHIFT) && w_isLast) begin
            w_soNext = r_par;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_so    <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_so    <= w_soNext;
            if (w_load) begin
                r_shreg <= din;
`ifdef PISO_TX_PARITY_EN
                r_par   <= ^din;
`endif
            end else if (r_state == SHIFT) begin
                r_shreg <= w_shifted;
            end
        end
    end

    assign so         = r_so;
    assign so_valid   = (r_state != IDLE);
    assign busy       = (r_state != IDLE);
    assign done       = w_final;
    assign load_ready = w_ready;

endmodule

// File: tb/tb_piso_tx.sv
// Table-driven self-checking bench for piso_tx: one MSB-first and one LSB-first instance
// share stimulus; expectations are hand-computed per cycle, with parity rows under PISO_TX_PARITY_EN.
module tb_piso_tx;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic       loadValid;

    logic mReady, mSo, mSoValid, mBusy, mDone;
    logic lReady, lSo, lSoValid, lBusy, lDone;

    int compared;
    int mismatched;

    typedef struct {
        logic       rst;
        logic       lv;
        logic [3:0] din;
        logic       soM;
        logic       soL;
        logic       v;
        logic       b;
        logic       d;
        logic       r;
    } row_t;

    row_t rows[$];

`ifdef PISO_TX_PARITY_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    piso_tx #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (loadValid),
        .load_ready (mReady),
        .so         (mSo),
        .so_valid   (mSoValid),
        .busy       (mBusy),
        .done       (mDone)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load_valid (loadValid),
        .load_ready (lReady),
        .so         (lSo),
        .so_valid   (lSoValid),
        .busy       (lBusy),
        .done       (lDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addRow(input logic r, input logic lv, input logic [3:0] d,
                          input logic soM, input logic soL, input logic v,
                          input logic b, input logic dn, input logic rdy);
        row_t t;
        t.rst = r; t.lv = lv; t.din = d; t.soM = soM; t.soL = soL;
        t.v = v; t.b = b; t.d = dn; t.r = rdy;
        rows.push_back(t);
    endtask

    task automatic checkOutput(input string name, input int idx, input logic act, input logic exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic lv, input logic [3:0] d);
        @(negedge clk);
        rst       = r;
        loadValid = lv;
        din       = d;
        #1;
    endtask

    initial begin
        int n;
        bit seen;

        rst = 1'b1; loadValid = 1'b0; din = 4'h0;
        repeat (2) @(posedge clk);

        // reset state (row checked while rst is still high, after reset edges)
        addRow(1, 0, 4'h0, 0, 0, 0, 0, 0, 1);

`ifdef PISO_TX_PARITY_EN
        // 0111 + parity 1, chained into 0011 + parity 0; din wiggles mid-frame
        addRow(0, 1, 4'b0111, 0, 0, 0, 0, 0, 1);
        addRow(0, 0, 4'b1000, 0, 1, 1, 1, 0, 0);
        addRow(0, 1, 4'b1111, 1, 1, 1, 1, 0, 0);
        addRow(0, 0, 4'b0000, 1, 1, 1, 1, 0, 0);
        addRow(0, 1, 4'b1010, 1, 0, 1, 1, 0, 0);
        addRow(0, 1, 4'b0011, 1, 1, 1, 1, 1, 1);
        addRow(0, 0, 4'b0000, 0, 1, 1, 1, 0, 0);
        addRow(0, 0, 4'b0000, 0, 1, 1, 1, 0, 0);
        addRow(0, 0, 4'b0000, 1, 0, 1, 1, 0, 0);
        addRow(0, 0, 4'b0000, 1, 0, 1, 1, 0, 0);
        addRow(0, 0, 4'b0000, 0, 0, 1, 1, 1, 1);
        addRow(0, 0, 4'b0000, 0, 0, 0, 0, 0, 1);
`else
        // single 1011 frame, din changed while busy
        addRow(0, 1, 4'b1011, 0, 0, 0, 0, 0, 1);
        addRow(0, 0, 4'b0000, 1, 1, 1, 1, 0, 0);
        addRow(0, 0, 4'b1111, 0, 1, 1, 1, 0, 0);
        addRow(0, 0, 4'b0000, 1, 0, 1, 1, 0, 0);
        addRow(0, 0, 4'b0000, 1, 1, 1, 1, 1, 1);
        addRow(0, 0, 4'b0000, 0, 0, 0, 0, 0, 1);
        // load_valid held: A then 5 back to back, 5 offered early must be ignored
        addRow(0, 1, 4'hA, 0, 0, 0, 0, 0, 1);
        addRow(0, 1, 4'h5, 1, 0, 1, 1, 0, 0);
        addRow(0, 1, 4'h5, 0, 1, 1, 1, 0, 0);
        addRow(0, 1, 4'h5, 1, 0, 1, 1, 0, 0);
        addRow(0, 1, 4'h5, 0, 1, 1, 1, 1, 1);
        addRow(0, 0, 4'h0, 0, 1, 1, 1, 0, 0);
        addRow(0, 0, 4'h0, 1, 0, 1, 1, 0, 0);
        addRow(0, 0, 4'h0, 0, 1, 1, 1, 0, 0);
        addRow(0, 0, 4'h0, 1, 0, 1, 1, 1, 1);
        addRow(0, 0, 4'h0, 0, 0, 0, 0, 0, 1);
`endif
        // reset on cycle 2 of a frame aborts it without a done pulse
        addRow(0, 1, 4'hF, 0, 0, 0, 0, 0, 1);
        addRow(0, 0, 4'h0, 1, 1, 1, 1, 0, 0);
        addRow(1, 1, 4'hF, 1, 1, 1, 1, 0, 0);
        addRow(0, 0, 4'h0, 0, 0, 0, 0, 0, 1);
        addRow(0, 0, 4'h0, 0, 0, 0, 0, 0, 1);
        // reset wins over a simultaneous load from IDLE
        addRow(1, 1, 4'hF, 0, 0, 0, 0, 0, 1);
        addRow(0, 0, 4'h0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < rows.size(); i++) begin
            applyStimulus(rows[i].rst, rows[i].lv, rows[i].din);
            checkOutput("so_msb",     i, mSo,      rows[i].soM);
            checkOutput("so_lsb",     i, lSo,      rows[i].soL);
            checkOutput("so_valid",   i, mSoValid, rows[i].v);
            checkOutput("busy",       i, mBusy,    rows[i].b);
            checkOutput("done",       i, mDone,    rows[i].d);
            checkOutput("load_ready", i, mReady,   rows[i].r);
            checkOutput("done_lsb",   i, lDone,    rows[i].d);
            checkOutput("busy_lsb",   i, lBusy,    rows[i].b);
        end

        // frame length measured up to the done pulse, bounded wait
        applyStimulus(0, 1, 4'b1100);
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            applyStimulus(0, 0, 4'h0);
            n++;
            if (mDone === 1'b1) seen = 1'b1;
        end
        compared++;
        if (!seen || n != FRAME_LEN) begin
            mismatched++;
            $display("[TB] FAIL frame_len: got %0d cycles (done seen %0b) expected %0d", n, seen, FRAME_LEN);
        end
        applyStimulus(0, 0, 4'h0);
        checkOutput("idle_after_len", 0, mSoValid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4: parallel word width in bits, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 means bit WIDTH-1 is sent first, 0 means bit 0 is sent first.
REQ-003 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-006 SHALL have port load_valid, input, 1 bit: din holds a valid word.
REQ-007 SHALL have port load_ready, output, 1 bit: the block accepts din this cycle.
REQ-008 SHALL have port so, output, 1 bit: registered serial data out.
REQ-009 SHALL have port so_valid, output, 1 bit: so carries a frame bit this cycle.
REQ-010 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking the last bit of a frame on so.

Function
REQ-012 SHALL implement states IDLE, SHIFT and, only when parity is compiled in, PARITY.
REQ-013 SHALL drive load_ready=1 in IDLE and in the final-bit cycle of a frame, and load_ready=0 in every other cycle.
REQ-014 SHALL, on load_valid&&load_ready, capture din into the shift register and move to SHIFT, with the first bit on so in the next cycle (latency 1).
REQ-015 SHALL hold so_valid=1 and busy=1 for exactly WIDTH consecutive cycles per frame, plus 1 cycle when the parity bit is compiled in.
REQ-016 SHALL shift the word out in the order selected by MSB_FIRST, one bit per cycle, with no gaps inside a frame.
REQ-017 SHALL use a bit counter $clog2(WIDTH+1) bits wide that loads WIDTH on capture, decrements once per bit, and never wraps below 0.
REQ-018 SHALL pulse done=1 in the cycle where the final frame bit (data bit or parity bit) is on so.
REQ-019 SHALL, on a load accepted during the final-bit cycle, start the next frame in the following cycle with no idle gap.
REQ-020 SHALL, after the final-bit cycle with no load accepted, return to IDLE with so=0, so_valid=0 and busy=0.
REQ-021 SHALL ignore load_valid whenever load_ready=0, and SHALL ignore changes on din while a frame is in progress.

Reset
REQ-022 SHALL, while rst=1 at a clk edge, force state to IDLE and counter to 0.
REQ-023 SHALL reset outputs to so=0, so_valid=0, busy=0, done=0, with load_ready=1 from the first cycle after reset.
REQ-024 SHALL let rst mid-frame abort the frame with no done pulse; the partial frame SHALL NOT resume.
REQ-025 SHALL give rst priority over a simultaneous load_valid.

Configuration
REQ-026 SHALL, with macro PISO_TX_PARITY_EN defined, append one even-parity bit (XOR of the captured word) after the data bits, using the PARITY state.
REQ-027 SHALL, with PISO_TX_PARITY_EN undefined, omit the PARITY state and the parity logic, giving frames of exactly WIDTH bits.

Structure
REQ-028 SHALL place the state enum type and a counter-width helper function in a shared package piso_pkg.
REQ-029 SHALL place the bit counter in sub-module piso_bit_counter, providing load, decrement and is-last outputs.

Verification
REQ-030 SHALL test: WIDTH=4, MSB_FIRST=1, din=4'b1011 loaded once -> so=1,0,1,1 on cycles 1-4, so_valid high for 4 cycles, done pulse on cycle 4.
REQ-031 SHALL test: MSB_FIRST=0, din=4'b1011 -> so=1,1,0,1.
REQ-032 SHALL test: load_valid held high with words 4'hA then 4'h5 -> 8 contiguous so_valid cycles sending 1010 then 0101, done pulses on cycles 4 and 8.
REQ-033 SHALL test: rst asserted on cycle 2 of a frame -> so=0, so_valid=0, no done pulse, load_ready=1 in the next cycle.
REQ-034 SHALL test: PISO_TX_PARITY_EN defined, din=4'b0111 -> so=0,1,1,1 then 1, with done on cycle 5.
REQ-035 SHALL test: din changed mid-frame while busy=1 -> serial output unaffected and load_ready stays 0 until the final-bit cycle.
